// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding
// and load-use hazard detection.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] imm_ext_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [2:0]        alu_control_d,
  input  logic              alu_src_d,
  input  logic              reg_write_d,
  input  logic              mem_read_d,
  input  logic              flush_e,
  input  logic              hold_e,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [DATA_W-1:0] result_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [DATA_W-1:0] src_a_e,
  output logic [DATA_W-1:0] src_b_e,
  output logic [2:0]        alu_control_e,
  output logic [DATA_W-1:0] write_data_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              reg_write_e,
  output logic              mem_read_e,
  output logic              valid_e,
  output logic              stall_d
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        alu_control;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  logic   lu;
  logic   hit1;
  logic   hit2;

  assign hit1 = (ex_q.rd == rs1_d);
  assign hit2 = (ex_q.rd == rs2_d);
  assign lu = ex_q.valid & ex_q.mem_read
            & (ex_q.rd != '0) & (hit1 | hit2)
            & valid_d;

  // Reset masks hold_e so the stall drops as soon as rst_n falls
  assign stall_d = rst_n & (lu | hold_e);

  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      flush_e: ex_d = '0;
      hold_e:  ex_d = ex_q;
      lu:      ex_d = '0;
      default: begin
        ex_d.valid       = valid_d;
        ex_d.rd1         = rd1_d;
        ex_d.rd2         = rd2_d;
        ex_d.imm         = imm_ext_d;
        ex_d.rs1         = rs1_d;
        ex_d.rs2         = rs2_d;
        ex_d.rd          = rd_d;
        ex_d.alu_control = alu_control_d;
        ex_d.alu_src     = alu_src_d;
        ex_d.reg_write   = reg_write_d & valid_d;
        ex_d.mem_read    = mem_read_d & valid_d;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] regval
  );
    logic [DATA_W-1:0] v;
    v = regval;
    if (reg_write_m && rd_m != '0 && rd_m == rs)
      v = alu_result_m;
    else if (reg_write_w && rd_w != '0 && rd_w == rs)
      v = result_w;
    return v;
  endfunction

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign fwd_a = fwd(ex_q.rs1, ex_q.rd1);
  assign fwd_b = fwd(ex_q.rs2, ex_q.rd2);

  assign src_a_e       = fwd_a;
  assign write_data_e  = fwd_b;
  assign src_b_e       = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign alu_control_e = ex_q.alu_control;
  assign rd_e          = ex_q.rd;
  assign reg_write_e   = ex_q.reg_write;
  assign mem_read_e    = ex_q.mem_read;
  assign valid_e       = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding,
// immediate select, load-use bubble, flush/hold.
module tb_id_ex_stage;
  logic        clk = 0;
  logic        rst_n;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  alu_control_d;
  logic        alu_src_d, reg_write_d, mem_read_d;
  logic        flush_e, hold_e;
  logic [31:0] alu_result_m, result_w;
  logic [4:0]  rd_m, rd_w;
  logic        reg_write_m, reg_write_w;
  logic [31:0] src_a_e, src_b_e, write_data_e;
  logic [2:0]  alu_control_e;
  logic [4:0]  rd_e;
  logic        reg_write_e, mem_read_e, valid_e, stall_d;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
    .reg_write_d(reg_write_d), .mem_read_d(mem_read_d),
    .flush_e(flush_e), .hold_e(hold_e),
    .alu_result_m(alu_result_m), .rd_m(rd_m),
    .reg_write_m(reg_write_m), .result_w(result_w),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e),
    .alu_control_e(alu_control_e),
    .write_data_e(write_data_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
    .valid_e(valid_e), .stall_d(stall_d)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1;
    valid_d = 1; rd1_d = 32'h123; rd2_d = 32'h456;
    imm_ext_d = 32'h789; rs1_d = 1; rs2_d = 2; rd_d = 3;
    alu_control_d = 3'b110; alu_src_d = 1;
    reg_write_d = 1; mem_read_d = 1;
    flush_e = 0; hold_e = 1;
    alu_result_m = 0; rd_m = 0; reg_write_m = 0;
    result_w = 0; rd_w = 0; reg_write_w = 0;
    #1 rst_n = 0;
    tick; tick;
    chk("rst_src_a", src_a_e, 0);
    chk("rst_src_b", src_b_e, 0);
    chk("rst_wdata", write_data_e, 0);
    chk("rst_aluc", {29'd0, alu_control_e}, 0);
    chk("rst_valid", {31'd0, valid_e}, 0);
    chk("rst_stall", {31'd0, stall_d}, 0);

    hold_e = 0; alu_src_d = 0; mem_read_d = 0;
    rd1_d = 32'h5; rd2_d = 32'h3; alu_control_d = 3'b001;
    rst_n = 1;
    tick;
    chk("cap_src_a", src_a_e, 32'h5);
    chk("cap_src_b", src_b_e, 32'h3);
    chk("cap_aluc", {29'd0, alu_control_e}, 1);
    chk("cap_valid", {31'd0, valid_e}, 1);
    chk("cap_regw", {31'd0, reg_write_e}, 1);

    rs1_d = 7; rd1_d = 32'h1111; rs2_d = 8; rd2_d = 32'h2;
    tick;
    rd_m = 7; alu_result_m = 32'hAAAA; reg_write_m = 1;
    rd_w = 7; result_w = 32'hBBBB; reg_write_w = 1;
    #1 chk("fwd_m_prio", src_a_e, 32'hAAAA);
    reg_write_m = 0;
    #1 chk("fwd_w", src_a_e, 32'hBBBB);
    reg_write_w = 0;
    #1 chk("fwd_none", src_a_e, 32'h1111);

    rs2_d = 0; rd2_d = 32'h22;
    tick;
    rd_m = 0; reg_write_m = 1; alu_result_m = 32'hFFFF;
    #1 chk("x0_src_b", src_b_e, 32'h22);
    chk("x0_wdata", write_data_e, 32'h22);

    alu_src_d = 1; imm_ext_d = 32'h10; rs2_d = 9; rd2_d = 32'h33;
    tick;
    rd_m = 9; reg_write_m = 1; alu_result_m = 32'hCCCC;
    #1 chk("imm_src_b", src_b_e, 32'h10);
    chk("imm_wdata", write_data_e, 32'hCCCC);
    reg_write_m = 0;

    rd_d = 4; mem_read_d = 1; reg_write_d = 1; valid_d = 1;
    rs1_d = 1; rs2_d = 2; imm_ext_d = 0;
    tick;
    chk("ld_memrd", {31'd0, mem_read_e}, 1);
    rs1_d = 4; rs2_d = 5; rd1_d = 32'h44; rd2_d = 32'h55;
    mem_read_d = 0; alu_src_d = 0; rd_d = 6;
    #1 chk("lu_stall", {31'd0, stall_d}, 1);
    tick;
    chk("lu_bub_valid", {31'd0, valid_e}, 0);
    chk("lu_bub_regw", {31'd0, reg_write_e}, 0);
    chk("lu_stall_drop", {31'd0, stall_d}, 0);
    rd_w = 4; reg_write_w = 1; result_w = 32'hDEAD;
    tick;
    chk("lu_cap_valid", {31'd0, valid_e}, 1);
    chk("lu_cap_rd", {27'd0, rd_e}, 6);
    chk("lu_fwd_w", src_a_e, 32'hDEAD);
    chk("lu_src_b", src_b_e, 32'h55);
    reg_write_w = 0;

    flush_e = 1; hold_e = 1;
    tick;
    chk("flush_win", {31'd0, valid_e}, 0);
    chk("flush_regw", {31'd0, reg_write_e}, 0);
    flush_e = 0; hold_e = 0;
    rd1_d = 32'h77; rs1_d = 10; rd_d = 11; alu_control_d = 3'b110;
    tick;
    chk("pre_hold_a", src_a_e, 32'h77);
    hold_e = 1;
    rd1_d = 32'h99; rd_d = 12; alu_control_d = 3'b010; valid_d = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", {31'd0, stall_d}, 1);
      tick;
      chk("hold_src_a", src_a_e, 32'h77);
      chk("hold_aluc", {29'd0, alu_control_e}, 3'b110);
      chk("hold_rd", {27'd0, rd_e}, 11);
      chk("hold_valid", {31'd0, valid_e}, 1);
    end

    hold_e = 0; valid_d = 0; reg_write_d = 1; mem_read_d = 1;
    tick;
    chk("inv_valid", {31'd0, valid_e}, 0);
    chk("inv_regw", {31'd0, reg_write_e}, 0);
    chk("inv_memrd", {31'd0, mem_read_e}, 0);

    hold_e = 1;
    #1 chk("hold_stall2", {31'd0, stall_d}, 1);
    rst_n = 0;
    #1 chk("rst_stall_clr", {31'd0, stall_d}, 0);
    chk("rst_aluc2", {29'd0, alu_control_e}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register with integrated operand forwarding and load-use hazard detection. Captures decoded operands and control each cycle and drives the execute-stage ALU inputs SrcAE, SrcBE and ALUControlE. Resolves RAW hazards by forwarding from the memory and writeback stages. Inserts a one-cycle bubble on a load-use hazard.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register-address width; register 0 is hardwired zero

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
valid_d  in  1  decode stage holds a valid instruction
rd1_d  in  DATA_W  register-file read data, source 1
rd2_d  in  DATA_W  register-file read data, source 2
imm_ext_d  in  DATA_W  extended immediate
rs1_d  in  REG_AW  source-1 address
rs2_d  in  REG_AW  source-2 address
rd_d  in  REG_AW  destination address
alu_control_d  in  3  ALU op code (000 upper-imm, 001 OR, 010 SLL, 011 SRL, 110 SLT)
alu_src_d  in  1  1 = SrcB is the immediate
reg_write_d  in  1  instruction writes rd
mem_read_d  in  1  instruction is a load
flush_e  in  1  squash the instruction entering execute (branch redirect)
hold_e  in  1  downstream stall; freeze the execute register
alu_result_m  in  DATA_W  memory-stage ALU result
rd_m  in  REG_AW  memory-stage destination
reg_write_m  in  1  memory-stage write enable
result_w  in  DATA_W  writeback result
rd_w  in  REG_AW  writeback destination
reg_write_w  in  1  writeback write enable
src_a_e  out  DATA_W  ALU SrcAE
src_b_e  out  DATA_W  ALU SrcBE
alu_control_e  out  3  ALU control
write_data_e  out  DATA_W  forwarded source-2 value, for stores
rd_e  out  REG_AW  execute destination
reg_write_e  out  1  execute write enable (0 for bubbles)
mem_read_e  out  1  execute load flag
valid_e  out  1  execute holds a real instruction
stall_d  out  1  freeze fetch/decode this cycle

Behaviour:
- Reset: rst_n low clears all execute registers (operands, imm, addresses, control, valid_e) to 0 asynchronously. This makes src_a_e, src_b_e, write_data_e and alu_control_e all 0, and stall_d 0. Release is synchronous to the next clk edge.
- Load-use hazard (combinational): lu = valid_e & mem_read_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d) & valid_d.
- stall_d = lu | hold_e.
- Register update on the rising clk edge, in priority order:
  1. flush_e: load a bubble (valid, reg_write, mem_read and alu_control all 0; data fields 0).
  2. hold_e: keep all contents unchanged.
  3. lu: load a bubble.
  4. Otherwise: capture all *_d inputs. valid_e <= valid_d. If valid_d = 0, force reg_write_e and mem_read_e to 0.
- Latency: 1 cycle from decode to execute outputs. Forwarding paths are combinational within the execute cycle.
- Forward select for operand A (B is identical using rs2_e):
  - M-stage value if reg_write_m & rd_m != 0 & rd_m == rs1_e.
  - Else W-stage value if reg_write_w & rd_w != 0 & rd_w == rs1_e.
  - Else registered rd1_e.
  - M has priority over W when both match.
- Register 0 is never forwarded; its registered value passes through.
- src_a_e = forwarded A.
- write_data_e = forwarded B.
- src_b_e = alu_src_e ? imm_ext_e : forwarded B. The immediate is never overridden by forwarding.
- Forwarding operates on bubble contents too; it is harmless because reg_write_e = 0.
- A load-use stall lasts exactly one cycle: after the bubble, valid_e = 0, so lu drops. The stalled instruction is captured on the following edge and receives the loaded value via W-stage forwarding.
- Simultaneous flush_e and hold_e: flush wins.
- rst_n asserted mid-stall clears stall_d immediately.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary inputs -> all outputs 0. Release, present rd1_d = 32'h5, rd2_d = 32'h3, alu_control_d = 001, valid_d = 1 -> next cycle src_a_e = 5, src_b_e = 3, alu_control_e = 001, valid_e = 1.
- M/W forwarding priority: rs1_e = 7 with rd_m = 7 (alu_result_m = 32'hAAAA) and rd_w = 7 (result_w = 32'hBBBB), both writes enabled -> src_a_e = 32'hAAAA. Drop reg_write_m -> src_a_e = 32'hBBBB.
- Register 0: rs2_e = 0, rd_m = 0, reg_write_m = 1, alu_result_m = 32'hFFFF, alu_src_e = 0 -> src_b_e equals the registered rd2_e, not 32'hFFFF.
- Immediate select: alu_src_d = 1, imm_ext_d = 32'h10, rs2 forwarding match active -> src_b_e = 32'h10, write_data_e = forwarded value.
- Load-use: load with rd = 4 in execute, decode rs1_d = 4 -> stall_d = 1 for exactly one cycle; next cycle valid_e = 0 and reg_write_e = 0; the cycle after, the instruction is captured and src_a_e = result_w.
- Flush vs hold: assert flush_e and hold_e together -> next cycle valid_e = 0. hold_e alone for 3 cycles -> all outputs unchanged and stall_d = 1 throughout.
